// File: rtl/instr_cycle_ctrl.sv
// instr_cycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer issuing beat and stage enables for the 16-bit RISC core.
module instr_cycle_ctrl #(
    parameter logic [4:0] HALT_OP = 5'b11111,
    parameter logic [4:0] NOP_OP  = 5'b11110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [3:0] beat,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       reg_we,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t r_state, w_next;

    logic w_alu, w_ld, w_st, w_jmp, w_jz, w_nop, w_halt, w_ill;

    assign w_alu  = opcode[4:3] == 2'b00;
    assign w_ld   = opcode == 5'b01000;
    assign w_st   = opcode == 5'b01001;
    assign w_jmp  = opcode == 5'b01010;
    assign w_jz   = opcode == 5'b01011;
    assign w_nop  = opcode == NOP_OP;
    assign w_halt = opcode == HALT_OP;
    assign w_ill  = !(w_alu || w_ld || w_st || w_jmp || w_jz || w_nop || w_halt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_halt ? S_HALT : S_EXEC;
            S_EXEC:   w_next = w_alu ? S_WB : (w_ld || w_st) ? S_MEM : S_FETCH;
            S_MEM:    w_next = !mem_ready ? S_MEM : w_ld ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = start ? S_FETCH : S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-only outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            beat    <= 4'b0000;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            reg_we  <= 1'b0;
            halted  <= 1'b0;
        end else begin
            r_state <= w_next;
            beat    <= (w_next == S_FETCH)  ? 4'b0001 :
                       (w_next == S_DECODE) ? 4'b0010 :
                       (w_next == S_EXEC || w_next == S_MEM) ? 4'b0100 :
                       (w_next == S_WB)     ? 4'b1000 : 4'b0000;
            mem_rd  <= w_next == S_FETCH || (w_next == S_MEM && w_ld);
            mem_wr  <= w_next == S_MEM && w_st;
            reg_we  <= w_next == S_WB;
            halted  <= w_next == S_HALT;
        end
    end

    // IR is only valid from DECODE and zero only in EXEC, so these decode live.
    assign ir_load = r_state == S_FETCH && mem_ready;
    assign pc_inc  = r_state == S_FETCH && mem_ready;
    assign pc_load = r_state == S_EXEC && (w_jmp || (w_jz && zero));
    assign illegal = r_state == S_DECODE && w_ill;
endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// tb_instr_cycle_ctrl: random instruction stream expanded into an expected per-cycle trace and compared cycle by cycle.
module tb_instr_cycle_ctrl;
    logic       clk, rst, start, mem_ready, zero;
    logic [4:0] opcode;
    logic [3:0] beat;
    logic       mem_rd, mem_wr, ir_load, pc_inc, pc_load, reg_we, halted, illegal;

    instr_cycle_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .beat(beat), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .reg_we(reg_we), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        r, s, mr, z;
        logic [4:0]  op;
        logic [11:0] ex;
    } ent_t;

    ent_t q[$];
    int   n_tot = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s: got beat/rd/wr/irl/pci/pcl/we/h/il=%b expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [11:0] o(input logic [3:0] b, input logic rd, wr, irl, pci, pcl, we, h, il);
        return {b, rd, wr, irl, pci, pcl, we, h, il};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic void push(input logic r, s, mr, z, input logic [4:0] op, input logic [11:0] ex);
        q.push_back('{r: r, s: s, mr: mr, z: z, op: op, ex: ex});
    endfunction

    function automatic void idle(input int k, input logic go);
        for (int i = 0; i < k; i++) push(0, 0, rb(), rb(), 5'($urandom), '0);
        if (go) push(0, 1, rb(), rb(), 5'($urandom), '0);
    endfunction

    function automatic void halt_wait(input int k);
        for (int i = 0; i < k; i++) push(0, 0, rb(), rb(), 5'($urandom), o(0, 0, 0, 0, 0, 0, 0, 1, 0));
        push(0, 1, rb(), rb(), 5'($urandom), o(0, 0, 0, 0, 0, 0, 0, 1, 0));
    endfunction

    // One instruction's cycles: fw fetch waits, mw memory waits, optional reset in the first MEM wait.
    function automatic void gen(input logic [4:0] op, input int fw, input int mw, input logic z, input logic abort);
        logic alu, ld, st, jmp, jz, hlt, ill;
        alu = op < 5'd8;
        ld  = op == 5'd8;
        st  = op == 5'd9;
        jmp = op == 5'd10;
        jz  = op == 5'd11;
        hlt = op == 5'd31;
        ill = !(alu || ld || st || jmp || jz || hlt || op == 5'd30);
        for (int i = 0; i < fw; i++) push(0, rb(), 0, rb(), 5'($urandom), o(1, 1, 0, 0, 0, 0, 0, 0, 0));
        push(0, rb(), 1, rb(), 5'($urandom), o(1, 1, 0, 1, 1, 0, 0, 0, 0));
        push(0, rb(), rb(), rb(), op, o(2, 0, 0, 0, 0, 0, 0, 0, ill));
        if (hlt) return;
        push(0, rb(), rb(), z, op, o(4, 0, 0, 0, 0, jmp || (jz && z), 0, 0, 0));
        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                push(abort && i == 0, rb(), 0, rb(), op, o(4, ld, st, 0, 0, 0, 0, 0, 0));
                if (abort) return;
            end
            push(0, rb(), 1, rb(), op, o(4, ld, st, 0, 0, 0, 0, 0, 0));
        end
        if (alu || ld) push(0, rb(), rb(), rb(), op, o(8, 0, 0, 0, 0, 0, 1, 0, 0));
    endfunction

    function automatic int waits();
        int r = $urandom_range(9);
        return r < 6 ? 0 : r < 9 ? 1 : 3;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
        idle(3, 1);
        gen(5'd0, 0, 0, 0, 0);
        gen(5'd8, 0, 2, 0, 0);
        gen(5'd11, 0, 0, 1, 0);
        gen(5'd11, 0, 0, 0, 0);
        gen(5'd9, 0, 0, 0, 0);
        gen(5'b10101, 0, 0, 0, 0);
        gen(5'd10, 1, 0, 0, 0);
        gen(5'd31, 0, 0, 0, 0);
        halt_wait(10);
        for (int n = 0; n < 160; n++) begin
            int r = $urandom_range(99);
            logic z = rb();
            if (r < 40) gen(5'($urandom_range(7)), waits(), 0, z, 0);
            else if (r < 50) gen(5'd8, waits(), waits(), z, 0);
            else if (r < 60) gen(5'd9, waits(), waits(), z, 0);
            else if (r < 67) gen(5'd10, waits(), 0, z, 0);
            else if (r < 77) gen(5'd11, waits(), 0, z, 0);
            else if (r < 83) gen(5'd30, waits(), 0, z, 0);
            else if (r < 91) gen(5'($urandom_range(29, 12)), waits(), 0, z, 0);
            else if (r < 96) begin
                gen(5'd31, waits(), 0, z, 0);
                halt_wait($urandom_range(6));
            end else begin
                gen(5'd9, waits(), 1 + $urandom_range(2), z, 1);
                idle($urandom_range(1, 4), 1);
            end
        end
        gen(5'd9, 0, 2, 0, 1);
        idle(6, 0);
        repeat (2) @(posedge clk);
        foreach (q[i]) begin
            #1;
            rst = q[i].r; start = q[i].s; mem_ready = q[i].mr; zero = q[i].z; opcode = q[i].op;
            @(negedge clk);
            chk($sformatf("cyc%0d", i),
                {beat, mem_rd, mem_wr, ir_load, pc_inc, pc_load, reg_we, halted, illegal}, q[i].ex);
            @(posedge clk);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
